// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences a shared-memory datapath (IR, A/B, ALUOut, MDR)
// through fetch/decode/execute states, stalling memory accesses on mem_ready.
module multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       retire,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   state_t cur, nxt;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= S_FETCH;
      else        cur <= nxt;
   end

   assign state = cur;

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      nxt           = cur;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      retire        = 1'b0;
      illegal_op    = 1'b0;

      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU precomputes PC + (imm << 2) into ALUOut for a possible branch.
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI:      nxt = S_ADDIEX;
               OP_J:         nxt = S_JUMP;
               default: begin
                  nxt        = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            nxt        = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nxt       = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            retire        = 1'b1;
            nxt           = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt       = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            nxt      = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase

      // Reset silences the datapath immediately, including a stalled write.
      if (!rst_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_src        = 2'b00;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         retire        = 1'b0;
         illegal_op    = 1'b0;
      end
   end

endmodule
